mor1kx_branch_resolver: RTL and testbench
=========================================

# mor1kx_branch_resolver

Execute-stage branch resolution unit for the mor1kx pipeline. It is the producer of the update-side signals consumed by the gshare branch predictor: `execute_op_bf`/`execute_op_bnf`, `prev_op_brcond`, `branch_mispredict` and `brn_pc`. It captures each decoded conditional branch together with its predicted flag, waits for the architectural flag, and pulses a one-cycle resolve/mispredict indication. On a mispredict it holds a fetch-redirect handshake, and it keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, width of PC values.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- padv_decode_i  in  1  decode stage advances this cycle.
- op_bf_i  in  1  decode instruction is l.bf.
- op_bnf_i  in  1  decode instruction is l.bnf.
- predicted_flag_i  in  1  predictor's flag prediction for the decode branch.
- pc_decode_i  in  OPTION_OPERAND_WIDTH  PC of the decode instruction.
- flag_i  in  1  architectural SR[F].
- flag_valid_i  in  1  flag_i is final for the pending branch.
- redirect_ready_i  in  1  fetch accepts the redirect.
- clear_counts_i  in  1  synchronous clear of both counters.
- execute_op_bf_o  out  1  pending branch is l.bf.
- execute_op_bnf_o  out  1  pending branch is l.bnf.
- prev_op_brcond_o  out  1  one-cycle resolve pulse.
- branch_mispredict_o  out  1  one-cycle mispredict pulse, coincident with prev_op_brcond_o.
- brn_pc_o  out  OPTION_OPERAND_WIDTH  PC of the pending/resolved branch.
- redirect_valid_o  out  1  fetch-redirect request.
- stall_o  out  1  decode must not advance.
- branch_count_o  out  CNT_WIDTH  resolved branches, saturating.
- mispredict_count_o  out  CNT_WIDTH  mispredicts, saturating.

## Operation
- FSM states are IDLE, WAIT_FLAG, RESOLVE and REDIRECT. Reset state is IDLE.
- stall_o = (state != IDLE). It is combinational from the state register.
- Capture happens only in IDLE, when padv_decode_i & (op_bf_i | op_bnf_i). On capture:
  - Register the branch type; op_bf_i has priority if both are high, giving execute_op_bf_o=1 and execute_op_bnf_o=0.
  - Register predicted_flag_i, and load pc_decode_i into brn_pc_o.
  - Go to WAIT_FLAG.
- Branch inputs are ignored in every state other than IDLE.
- flag_valid_i is ignored outside WAIT_FLAG.
- WAIT_FLAG: when flag_valid_i=1, register mispredict = (flag_i != stored predicted flag) and go to RESOLVE. Otherwise hold.
- RESOLVE (exactly one cycle):
  - prev_op_brcond_o=1, and branch_mispredict_o = registered mispredict.
  - execute_op_*_o and brn_pc_o remain valid.
  - Next state is REDIRECT if mispredict, else IDLE.
- REDIRECT:
  - redirect_valid_o=1, and brn_pc_o is held stable.
  - On redirect_ready_i=1 (sampled at the edge), go to IDLE.
  - Valid must never drop before ready.
- Leaving RESOLVE (non-mispredict) or REDIRECT clears execute_op_bf_o and execute_op_bnf_o to 0. brn_pc_o retains its last value.
- Counters:
  - branch_count_o increments on the edge that enters RESOLVE.
  - mispredict_count_o also increments on that edge, only when mispredict is set.
  - Both saturate at all-ones; there is no wrap.
  - clear_counts_i has priority over increment in the same cycle.

## Timing
- Reset (rst=0) takes effect immediately, without waiting for a clock. All outputs go to 0, counters to 0, and state to IDLE.
- Reset mid-operation abandons any pending branch or redirect; no resolve pulse is generated.
- Minimum latency runs from the capture edge:
  - Capture at edge 0: WAIT_FLAG during cycle 1.
  - flag_valid_i=1 in cycle 1: RESOLVE in cycle 2, with the pulse visible in cycle 2.
  - Correct prediction: IDLE in cycle 3, so the next branch can be captured in cycle 3.
- Mispredict with redirect_ready_i already high: REDIRECT in cycle 3, IDLE in cycle 4.
- prev_op_brcond_o and branch_mispredict_o are registered outputs, high for exactly one cycle per branch.
- Counter values are updated in the same cycle that the RESOLVE pulse is visible.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0 and stall_o=0. Assert rst=0 during REDIRECT → redirect_valid_o drops without a clock edge.
- Correct l.bf:
  - Stimulus: capture with predicted_flag_i=1, pc_decode_i=0x100; flag_valid_i=1, flag_i=1 one cycle later.
  - Required: prev_op_brcond_o=1 and branch_mispredict_o=0 in cycle 2, with execute_op_bf_o=1 and brn_pc_o=0x100; branch_count_o=1; IDLE in cycle 3.
- Mispredicted l.bnf:
  - Stimulus: predicted_flag_i=0, flag_i=1, redirect_ready_i held low for 3 cycles.
  - Required: branch_mispredict_o pulses once; redirect_valid_o stays high and brn_pc_o stays stable until ready; mispredict_count_o=1; stall_o high throughout.
- Delayed flag: flag_valid_i low for 5 cycles after capture → stall_o high, no pulse, and a new op_bf_i with padv_decode_i is ignored (brn_pc_o unchanged).
- Both op_bf_i and op_bnf_i high at capture → execute_op_bf_o=1 and execute_op_bnf_o=0.
- Counters:
  - Force CNT_WIDTH=4 and resolve 17 branches → branch_count_o saturates at 15.
  - Assert clear_counts_i in a RESOLVE cycle → count reads 0 next cycle.

Source files
------------

// File: rtl/mor1kx_branch_resolver.sv
// Execute-stage branch resolution for the mor1kx pipeline.
// The unit captures one conditional branch (l.bf/l.bnf) with its predicted flag
// and waits for the architectural flag. It then pulses resolve/mispredict for one
// cycle and, on a mispredict, holds a fetch-redirect request until fetch accepts it.
// It also keeps saturating counters of resolved branches and mispredicts.
module mor1kx_branch_resolver #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic                            op_bf_i,
  input  logic                            op_bnf_i,
  input  logic                            predicted_flag_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pc_decode_i,
  input  logic                            flag_i,
  input  logic                            flag_valid_i,
  input  logic                            redirect_ready_i,
  input  logic                            clear_counts_i,
  output logic                            execute_op_bf_o,
  output logic                            execute_op_bnf_o,
  output logic                            prev_op_brcond_o,
  output logic                            branch_mispredict_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_o,
  output logic                            redirect_valid_o,
  output logic                            stall_o,
  output logic [CNT_WIDTH-1:0]            branch_count_o,
  output logic [CNT_WIDTH-1:0]            mispredict_count_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FLAG = 2'd1,
    RESOLVE   = 2'd2,
    REDIRECT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                            op_bf_q,  op_bf_d;
  logic                            op_bnf_q, op_bnf_d;
  logic                            pred_q,   pred_d;
  logic [OPTION_OPERAND_WIDTH-1:0] pc_q,     pc_d;
  logic                            mispred_q, mispred_d;
  logic                            brcond_q, brcond_d;
  logic                            mp_pulse_q, mp_pulse_d;
  logic [CNT_WIDTH-1:0]            bcnt_q,   bcnt_d;
  logic [CNT_WIDTH-1:0]            mcnt_q,   mcnt_d;

  logic capture;
  logic flag_done;
  logic flag_mismatch;
  logic ops_clear;

  assign capture       = (state_q == IDLE) && padv_decode_i && (op_bf_i || op_bnf_i);
  assign flag_done     = (state_q == WAIT_FLAG) && flag_valid_i;
  assign flag_mismatch = (flag_i != pred_q);
  // Branch type is dropped when the branch retires: a correct resolve or an accepted redirect.
  assign ops_clear     = ((state_q == RESOLVE) && !mispred_q) ||
                         ((state_q == REDIRECT) && redirect_ready_i);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (capture)          state_d = WAIT_FLAG;
      WAIT_FLAG: if (flag_valid_i)     state_d = RESOLVE;
      RESOLVE:   state_d = mispred_q ? REDIRECT : IDLE;
      REDIRECT:  if (redirect_ready_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    stall_o          = 1'b0;
    redirect_valid_o = 1'b0;
    unique case (state_q)
      IDLE:      ;
      WAIT_FLAG: stall_o = 1'b1;
      RESOLVE:   stall_o = 1'b1;
      REDIRECT:  begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
      end
      default:   ;
    endcase
  end

  // Branch capture and resolve datapath next-state.
  always_comb begin
    op_bf_d    = op_bf_q;
    op_bnf_d   = op_bnf_q;
    pred_d     = pred_q;
    pc_d       = pc_q;
    mispred_d  = mispred_q;
    brcond_d   = flag_done;
    mp_pulse_d = flag_done && flag_mismatch;
    if (capture) begin
      op_bf_d  = op_bf_i;
      op_bnf_d = !op_bf_i && op_bnf_i;
      pred_d   = predicted_flag_i;
      pc_d     = pc_decode_i;
    end else if (ops_clear) begin
      op_bf_d  = 1'b0;
      op_bnf_d = 1'b0;
    end
    if (flag_done) mispred_d = flag_mismatch;
  end

  // Branch capture and resolve datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_bf_q    <= 1'b0;
      op_bnf_q   <= 1'b0;
      pred_q     <= 1'b0;
      pc_q       <= '0;
      mispred_q  <= 1'b0;
      brcond_q   <= 1'b0;
      mp_pulse_q <= 1'b0;
    end else begin
      op_bf_q    <= op_bf_d;
      op_bnf_q   <= op_bnf_d;
      pred_q     <= pred_d;
      pc_q       <= pc_d;
      mispred_q  <= mispred_d;
      brcond_q   <= brcond_d;
      mp_pulse_q <= mp_pulse_d;
    end
  end

  // Saturating statistics next-state; clear wins over increment.
  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (clear_counts_i) begin
      bcnt_d = '0;
      mcnt_d = '0;
    end else if (flag_done) begin
      if (bcnt_q != '1)                  bcnt_d = bcnt_q + 1'b1;
      if (flag_mismatch && mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign execute_op_bf_o     = op_bf_q;
  assign execute_op_bnf_o    = op_bnf_q;
  assign prev_op_brcond_o    = brcond_q;
  assign branch_mispredict_o = mp_pulse_q;
  assign brn_pc_o            = pc_q;
  assign branch_count_o      = bcnt_q;
  assign mispredict_count_o  = mcnt_q;

endmodule

// File: tb/tb_mor1kx_branch_resolver.sv
// Directed bench for mor1kx_branch_resolver: a table of single-branch vectors
// plus hand sequences for redirect backpressure, delayed flag, saturation,
// clear priority and asynchronous reset.
module tb_mor1kx_branch_resolver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        padv_decode_i = 1'b0;
  logic        op_bf_i = 1'b0;
  logic        op_bnf_i = 1'b0;
  logic        predicted_flag_i = 1'b0;
  logic [31:0] pc_decode_i = '0;
  logic        flag_i = 1'b0;
  logic        flag_valid_i = 1'b0;
  logic        redirect_ready_i = 1'b0;
  logic        clear_counts_i = 1'b0;

  logic        ex_bf, ex_bnf, brcond, misp, rvalid, stall;
  logic [31:0] brn_pc;
  logic [15:0] bcnt, mcnt;

  logic        s_ex_bf, s_ex_bnf, s_brcond, s_misp, s_rvalid, s_stall;
  logic [31:0] s_brn_pc;
  logic [3:0]  s_bcnt, s_mcnt;

  mor1kx_branch_resolver #(.OPTION_OPERAND_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .padv_decode_i(padv_decode_i), .op_bf_i(op_bf_i),
    .op_bnf_i(op_bnf_i), .predicted_flag_i(predicted_flag_i), .pc_decode_i(pc_decode_i),
    .flag_i(flag_i), .flag_valid_i(flag_valid_i), .redirect_ready_i(redirect_ready_i),
    .clear_counts_i(clear_counts_i), .execute_op_bf_o(ex_bf), .execute_op_bnf_o(ex_bnf),
    .prev_op_brcond_o(brcond), .branch_mispredict_o(misp), .brn_pc_o(brn_pc),
    .redirect_valid_o(rvalid), .stall_o(stall), .branch_count_o(bcnt),
    .mispredict_count_o(mcnt));

  mor1kx_branch_resolver #(.OPTION_OPERAND_WIDTH(32), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .padv_decode_i(padv_decode_i), .op_bf_i(op_bf_i),
    .op_bnf_i(op_bnf_i), .predicted_flag_i(predicted_flag_i), .pc_decode_i(pc_decode_i),
    .flag_i(flag_i), .flag_valid_i(flag_valid_i), .redirect_ready_i(redirect_ready_i),
    .clear_counts_i(clear_counts_i), .execute_op_bf_o(s_ex_bf), .execute_op_bnf_o(s_ex_bnf),
    .prev_op_brcond_o(s_brcond), .branch_mispredict_o(s_misp), .brn_pc_o(s_brn_pc),
    .redirect_valid_o(s_rvalid), .stall_o(s_stall), .branch_count_o(s_bcnt),
    .mispredict_count_o(s_mcnt));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_bc = 0;
  int exp_mc = 0;

  typedef struct {
    logic        bf, bnf, pred;
    logic [31:0] pc;
    logic        flag;
    logic        exp_bf, exp_bnf, exp_misp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    padv_decode_i = 1'b0; op_bf_i = 1'b0; op_bnf_i = 1'b0; predicted_flag_i = 1'b0;
    pc_decode_i = '0; flag_i = 1'b0; flag_valid_i = 1'b0; clear_counts_i = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_bf"}, ex_bf, 0);
    chk({tag, "_bnf"}, ex_bnf, 0);
    chk({tag, "_brcond"}, brcond, 0);
    chk({tag, "_misp"}, misp, 0);
    chk({tag, "_pc"}, brn_pc, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_bcnt"}, bcnt, 0);
    chk({tag, "_mcnt"}, mcnt, 0);
  endtask

  // Capture a branch in the current cycle and advance one edge (now in WAIT_FLAG).
  task automatic capture(input logic bf, input logic bnf, input logic pred, input logic [31:0] pc);
    padv_decode_i = 1'b1; op_bf_i = bf; op_bnf_i = bnf;
    predicted_flag_i = pred; pc_decode_i = pc;
    tick();
    padv_decode_i = 1'b0; op_bf_i = 1'b0; op_bnf_i = 1'b0;
  endtask

  // Present the final flag for one cycle; afterwards the DUT is in RESOLVE.
  task automatic give_flag(input logic f);
    flag_valid_i = 1'b1; flag_i = f;
    tick();
    flag_valid_i = 1'b0; flag_i = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    redirect_ready_i = 1'b1;
    capture(v.bf, v.bnf, v.pred, v.pc);
    chk($sformatf("v%0d_wait_stall", i), stall, 1);
    chk($sformatf("v%0d_wait_brcond", i), brcond, 0);
    chk($sformatf("v%0d_wait_pc", i), brn_pc, v.pc);
    give_flag(v.flag);
    exp_bc++;
    if (v.exp_misp) exp_mc++;
    chk($sformatf("v%0d_brcond", i), brcond, 1);
    chk($sformatf("v%0d_misp", i), misp, v.exp_misp);
    chk($sformatf("v%0d_ex_bf", i), ex_bf, v.exp_bf);
    chk($sformatf("v%0d_ex_bnf", i), ex_bnf, v.exp_bnf);
    chk($sformatf("v%0d_pc", i), brn_pc, v.pc);
    chk($sformatf("v%0d_bcnt", i), bcnt, exp_bc);
    chk($sformatf("v%0d_mcnt", i), mcnt, exp_mc);
    tick();
    if (v.exp_misp) begin
      chk($sformatf("v%0d_redir_valid", i), rvalid, 1);
      chk($sformatf("v%0d_redir_stall", i), stall, 1);
      chk($sformatf("v%0d_redir_pulse", i), brcond, 0);
      tick();
    end
    chk($sformatf("v%0d_idle_stall", i), stall, 0);
    chk($sformatf("v%0d_idle_rvalid", i), rvalid, 0);
    chk($sformatf("v%0d_idle_brcond", i), brcond, 0);
    chk($sformatf("v%0d_idle_bf", i), ex_bf | ex_bnf, 0);
    chk($sformatf("v%0d_idle_pc", i), brn_pc, v.pc);
  endtask

  initial begin
    //           bf    bnf   pred  pc             flag  ebf   ebnf  emisp
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0300, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held with random inputs: everything stays zero.
    for (int c = 0; c < 4; c++) begin
      padv_decode_i = 1'($urandom); op_bf_i = 1'($urandom); op_bnf_i = 1'($urandom);
      predicted_flag_i = 1'($urandom); pc_decode_i = $urandom; flag_i = 1'($urandom);
      flag_valid_i = 1'($urandom); redirect_ready_i = 1'($urandom);
      clear_counts_i = 1'($urandom);
      tick();
    end
    all_zero("rst");
    idle_inputs();
    redirect_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // flag_valid_i outside WAIT_FLAG has no effect.
    flag_valid_i = 1'b1; flag_i = 1'b1;
    tick();
    flag_valid_i = 1'b0; flag_i = 1'b0;
    chk("idle_flag_stall", stall, 0);
    chk("idle_flag_brcond", brcond, 0);
    chk("idle_flag_bcnt", bcnt, 0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Mispredicted l.bnf with redirect held off for 3 cycles.
    redirect_ready_i = 1'b0;
    capture(1'b0, 1'b1, 1'b0, 32'h0000_05A0);
    give_flag(1'b1);
    exp_bc++; exp_mc++;
    chk("bp_misp", misp, 1);
    chk("bp_ex_bnf", ex_bnf, 1);
    chk("bp_mcnt", mcnt, exp_mc);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp_rvalid%0d", c), rvalid, 1);
      chk($sformatf("bp_pc%0d", c), brn_pc, 32'h0000_05A0);
      chk($sformatf("bp_stall%0d", c), stall, 1);
      chk($sformatf("bp_nopulse%0d", c), {brcond, misp}, 0);
    end
    redirect_ready_i = 1'b1;
    tick();
    chk("bp_done_rvalid", rvalid, 0);
    chk("bp_done_stall", stall, 0);
    chk("bp_done_bnf", ex_bnf, 0);
    chk("bp_done_mcnt", mcnt, exp_mc);

    // Delayed flag: decode branch attempts are ignored while waiting.
    capture(1'b1, 1'b0, 1'b1, 32'h0000_0700);
    for (int c = 0; c < 5; c++) begin
      padv_decode_i = 1'b1; op_bf_i = 1'b1; pc_decode_i = 32'h0000_0999;
      predicted_flag_i = 1'b0;
      tick();
      chk($sformatf("dly_stall%0d", c), stall, 1);
      chk($sformatf("dly_pulse%0d", c), brcond, 0);
      chk($sformatf("dly_pc%0d", c), brn_pc, 32'h0000_0700);
    end
    padv_decode_i = 1'b0; op_bf_i = 1'b0; pc_decode_i = '0;
    give_flag(1'b1);
    exp_bc++;
    chk("dly_brcond", brcond, 1);
    chk("dly_misp", misp, 0);
    chk("dly_bcnt", bcnt, exp_bc);
    tick();
    chk("dly_idle", stall, 0);

    // Saturation on the 4-bit instance after a clear.
    clear_counts_i = 1'b1;
    tick();
    clear_counts_i = 1'b0;
    exp_bc = 0; exp_mc = 0;
    chk("clr_bcnt", bcnt, 0);
    chk("clr_small_bcnt", s_bcnt, 0);
    for (int n = 1; n <= 17; n++) begin
      capture(1'b1, 1'b0, 1'b1, 32'h0000_1000 + 32'(n));
      give_flag(1'b1);
      tick();
      if (n == 15) chk("sat_small_15", s_bcnt, 15);
    end
    chk("sat_small_17", s_bcnt, 15);
    chk("sat_main_17", bcnt, 17);
    chk("sat_small_mcnt", s_mcnt, 0);

    // Clear asserted during the RESOLVE cycle wins over later state.
    capture(1'b1, 1'b0, 1'b0, 32'h0000_2000);
    give_flag(1'b1);
    chk("clrres_bcnt", bcnt, 18);
    chk("clrres_mcnt", mcnt, 1);
    clear_counts_i = 1'b1;
    tick();
    clear_counts_i = 1'b0;
    chk("clrres_bcnt0", bcnt, 0);
    chk("clrres_mcnt0", mcnt, 0);
    chk("clrres_rvalid", rvalid, 1);
    tick();

    // Asynchronous reset during REDIRECT.
    redirect_ready_i = 1'b0;
    capture(1'b0, 1'b1, 1'b1, 32'h0000_3000);
    give_flag(1'b0);
    tick();
    chk("ar_pre_rvalid", rvalid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_rvalid", rvalid, 0);
    chk("ar_stall", stall, 0);
    chk("ar_pc", brn_pc, 0);
    chk("ar_bnf", ex_bnf, 0);
    chk("ar_bcnt", bcnt, 0);
    tick();
    all_zero("ar_held");
    @(negedge clk);
    rst = 1'b1;
    redirect_ready_i = 1'b1;
    tick();
    chk("ar_after_pulse", {brcond, misp, rvalid, stall}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
